// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter for the accumulator CPU.
// Supports increment, absolute jump, conditional relative branch, a bounded
// LIFO of return addresses for CALL/RET, and sticky HALTED/FAULT states.
// All state advances on the falling edge of i_clk; outputs come straight
// from registers, so they show the result of the op sampled one edge earlier.
module pc_stack_unit #(
    parameter int N_ADDR      = 11,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_ADDR  = 0
) (
    input  logic                               i_clk,
    input  logic                               i_reset,
    input  logic                               i_en,
    input  logic [2:0]                         i_op,
    input  logic                               i_cond,
    input  logic [N_ADDR-1:0]                  i_target,
    input  logic [N_ADDR-1:0]                  i_offset,
    output logic [N_ADDR-1:0]                  o_pc,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   o_depth,
    output logic                               o_halted,
    output logic                               o_fault,
    output logic [1:0]                         o_fault_code
);

    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    localparam logic [N_ADDR-1:0]  RST_PC     = N_ADDR'(RESET_ADDR);
    localparam logic [DEPTH_W-1:0] FULL_DEPTH = DEPTH_W'(STACK_DEPTH);

    localparam logic [2:0] OP_INC    = 3'b001;
    localparam logic [2:0] OP_JUMP   = 3'b010;
    localparam logic [2:0] OP_BRANCH = 3'b011;
    localparam logic [2:0] OP_CALL   = 3'b100;
    localparam logic [2:0] OP_RET    = 3'b101;
    localparam logic [2:0] OP_HALT   = 3'b110;

    localparam logic [1:0] CODE_NONE      = 2'b00;
    localparam logic [1:0] CODE_OVERFLOW  = 2'b01;
    localparam logic [1:0] CODE_UNDERFLOW = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_HALTED = 2'b01,
        ST_FAULT  = 2'b10
    } state_t;

    // Relative branch target: base plus a sign-interpreted offset, wrapping
    // modulo 2^N_ADDR with no overflow detection.
    function automatic logic [N_ADDR-1:0] add_offset(
        input logic        [N_ADDR-1:0] base,
        input logic signed [N_ADDR-1:0] off
    );
        return base + $unsigned(off);
    endfunction

    state_t              r_state;
    logic [N_ADDR-1:0]   r_pc;
    logic [DEPTH_W-1:0]  r_depth;
    logic [1:0]          r_fault_code;
    logic [N_ADDR-1:0]   r_stack [STACK_DEPTH];

    state_t              w_state_next;
    logic [N_ADDR-1:0]   w_pc_next;
    logic [DEPTH_W-1:0]  w_depth_next;
    logic [1:0]          w_code_next;
    logic                w_push;
    logic [N_ADDR-1:0]   w_pc_inc;
    logic [DEPTH_W-1:0]  w_depth_dec;
    logic [N_ADDR-1:0]   w_pop_data;

    assign w_pc_inc    = r_pc + N_ADDR'(1);
    assign w_depth_dec = r_depth - DEPTH_W'(1);

    // Select the top-of-stack entry (entry [depth-1]) for RET.
    always_comb begin
        w_pop_data = '0;
        for (int k = 0; k < STACK_DEPTH; k++) begin
            if (w_depth_dec == DEPTH_W'(k)) begin
                w_pop_data = r_stack[k];
            end
        end
    end

    // Next-state and datapath decode; only RUN with i_en set can change anything.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_depth_next = r_depth;
        w_code_next  = r_fault_code;
        w_push       = 1'b0;
        if (r_state == ST_RUN && i_en) begin
            case (i_op)
                OP_INC:    w_pc_next = w_pc_inc;
                OP_JUMP:   w_pc_next = i_target;
                OP_BRANCH: w_pc_next = i_cond ? add_offset(w_pc_inc, i_offset) : w_pc_inc;
                OP_CALL: begin
                    if (r_depth != FULL_DEPTH) begin
                        w_push       = 1'b1;
                        w_depth_next = r_depth + DEPTH_W'(1);
                        w_pc_next    = i_target;
                    end else begin
                        w_state_next = ST_FAULT;
                        w_code_next  = CODE_OVERFLOW;
                    end
                end
                OP_RET: begin
                    if (r_depth != '0) begin
                        w_pc_next    = w_pop_data;
                        w_depth_next = w_depth_dec;
                    end else begin
                        w_state_next = ST_FAULT;
                        w_code_next  = CODE_UNDERFLOW;
                    end
                end
                OP_HALT:   w_state_next = ST_HALTED;
                default:   ;
            endcase
        end
    end

    // Control and PC registers; reset overrides any op in flight.
    always_ff @(negedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_RUN;
            r_pc         <= RST_PC;
            r_depth      <= '0;
            r_fault_code <= CODE_NONE;
        end else begin
            r_state      <= w_state_next;
            r_pc         <= w_pc_next;
            r_depth      <= w_depth_next;
            r_fault_code <= w_code_next;
        end
    end

    // Return-address array: write pc+1 into entry [depth] on a push.
    // Contents are never cleared; depth alone defines which entries are valid.
    always_ff @(negedge i_clk) begin
        for (int k = 0; k < STACK_DEPTH; k++) begin
            if (w_push && !i_reset && r_depth == DEPTH_W'(k)) begin
                r_stack[k] <= w_pc_inc;
            end
        end
    end

    assign o_pc         = r_pc;
    assign o_depth      = r_depth;
    assign o_halted     = (r_state == ST_HALTED);
    assign o_fault      = (r_state == ST_FAULT);
    assign o_fault_code = r_fault_code;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Bench for pc_stack_unit: directed vector table followed by randomized ops
// checked against a queue-based reference model.
module tb_pc_stack_unit;

    localparam int N     = 11;
    localparam int DEPTH = 4;
    localparam int MASK  = (1 << N) - 1;

    logic          clk;
    logic          rst;
    logic          en;
    logic [2:0]    op;
    logic          cond;
    logic [N-1:0]  target;
    logic [N-1:0]  offset;
    logic [N-1:0]  pc;
    logic [2:0]    depth;
    logic          halted;
    logic          fault;
    logic [1:0]    code;

    pc_stack_unit #(.N_ADDR(N), .STACK_DEPTH(DEPTH), .RESET_ADDR(0)) dut (
        .i_clk(clk), .i_reset(rst), .i_en(en), .i_op(op), .i_cond(cond),
        .i_target(target), .i_offset(offset), .o_pc(pc), .o_depth(depth),
        .o_halted(halted), .o_fault(fault), .o_fault_code(code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit        rst;
        bit        en;
        bit [2:0]  op;
        bit        cond;
        int        target;
        int        offset;
        int        exp_pc;
        int        exp_depth;
        bit        exp_halt;
        bit        exp_fault;
        int        exp_code;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // reference model state
    int   m_pc;
    int   m_stk[$];
    bit   m_halt;
    bit   m_fault;
    int   m_code;

    function automatic void add(bit r, bit e, bit [2:0] o, bit c, int t, int f,
                                int epc, int ed, bit eh, bit ef, int ec);
        vec_t v;
        v = '{r, e, o, c, t, f, epc, ed, eh, ef, ec};
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input int idx, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0h want %0h", nm, idx, got, want);
        end
    endtask

    // drive on the rising edge, DUT updates on the falling edge, sample just after
    task automatic step(input bit r, input bit e, input bit [2:0] o, input bit c,
                        input int t, input int f);
        @(posedge clk);
        rst    = r;
        en     = e;
        op     = o;
        cond   = c;
        target = N'(t);
        offset = N'(f);
        @(negedge clk);
        #1;
    endtask

    function automatic void model(bit r, bit e, bit [2:0] o, bit c, int t, int f);
        int off_s;
        if (r) begin
            m_pc = 0; m_stk.delete(); m_halt = 0; m_fault = 0; m_code = 0;
        end else if (!m_halt && !m_fault && e) begin
            case (o)
                3'd1: m_pc = (m_pc + 1) & MASK;
                3'd2: m_pc = t & MASK;
                3'd3: begin
                    off_s = (f >= (1 << (N - 1))) ? f - (1 << N) : f;
                    m_pc  = c ? ((m_pc + 1 + off_s) & MASK) : ((m_pc + 1) & MASK);
                end
                3'd4: begin
                    if (m_stk.size() < DEPTH) begin
                        m_stk.push_back((m_pc + 1) & MASK);
                        m_pc = t & MASK;
                    end else begin
                        m_fault = 1; m_code = 1;
                    end
                end
                3'd5: begin
                    if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                    else begin m_fault = 1; m_code = 2; end
                end
                3'd6: m_halt = 1;
                default: ;
            endcase
        end
    endfunction

    initial begin
        rst = 1'b1; en = 1'b0; op = 3'd0; cond = 1'b0; target = '0; offset = '0;

        //   rst en op  c  target  offset  pc     d  h  f  code
        add(1, 0, 0, 0, 0,      0,      'h000, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0,      0,      'h001, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0,      0,      'h002, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0,      0,      'h003, 0, 0, 0, 0);
        add(0, 1, 2, 0, 'h7FF,  0,      'h7FF, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0,      0,      'h000, 0, 0, 0, 0);
        add(0, 0, 2, 0, 'h123,  0,      'h000, 0, 0, 0, 0);
        add(0, 1, 2, 0, 'h010,  0,      'h010, 0, 0, 0, 0);
        add(0, 1, 3, 1, 'h3AA,  'h7FE,  'h00F, 0, 0, 0, 0);
        add(0, 1, 3, 0, 0,      'h7FE,  'h010, 0, 0, 0, 0);
        add(0, 1, 2, 0, 'h005,  0,      'h005, 0, 0, 0, 0);
        add(0, 1, 4, 0, 'h100,  0,      'h100, 1, 0, 0, 0);
        add(0, 1, 4, 0, 'h200,  0,      'h200, 2, 0, 0, 0);
        add(0, 1, 5, 0, 0,      0,      'h101, 1, 0, 0, 0);
        add(0, 1, 5, 0, 0,      0,      'h006, 0, 0, 0, 0);
        add(0, 1, 4, 0, 'h300,  0,      'h300, 1, 0, 0, 0);
        add(0, 1, 4, 0, 'h301,  0,      'h301, 2, 0, 0, 0);
        add(0, 1, 4, 0, 'h302,  0,      'h302, 3, 0, 0, 0);
        add(0, 1, 4, 0, 'h303,  0,      'h303, 4, 0, 0, 0);
        add(0, 1, 4, 0, 'h304,  0,      'h303, 4, 0, 1, 1);
        add(0, 1, 1, 0, 0,      0,      'h303, 4, 0, 1, 1);
        add(1, 0, 0, 0, 0,      0,      'h000, 0, 0, 0, 0);
        add(0, 1, 5, 0, 0,      0,      'h000, 0, 0, 1, 2);
        add(1, 0, 0, 0, 0,      0,      'h000, 0, 0, 0, 0);
        add(0, 1, 2, 0, 'h042,  0,      'h042, 0, 0, 0, 0);
        add(0, 1, 6, 0, 0,      0,      'h042, 0, 1, 0, 0);
        add(0, 1, 1, 0, 0,      0,      'h042, 0, 1, 0, 0);
        add(0, 1, 2, 0, 'h155,  0,      'h042, 0, 1, 0, 0);
        add(1, 0, 0, 0, 0,      0,      'h000, 0, 0, 0, 0);
        add(0, 1, 4, 0, 'h100,  0,      'h100, 1, 0, 0, 0);
        add(1, 1, 4, 0, 'h200,  0,      'h000, 0, 0, 0, 0);
        add(0, 1, 5, 0, 0,      0,      'h000, 0, 0, 1, 2);
        add(1, 0, 0, 0, 0,      0,      'h000, 0, 0, 0, 0);
        add(0, 1, 2, 0, 'h7FF,  0,      'h7FF, 0, 0, 0, 0);
        add(0, 1, 4, 0, 'h010,  0,      'h010, 1, 0, 0, 0);
        add(0, 1, 5, 0, 0,      0,      'h000, 0, 0, 0, 0);
        add(0, 1, 3, 1, 0,      'h004,  'h005, 0, 0, 0, 0);
        add(0, 1, 7, 1, 'h222,  'h100,  'h005, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].op, vecs[i].cond,
                 vecs[i].target, vecs[i].offset);
            chk("pc",     i, int'(pc),     vecs[i].exp_pc);
            chk("depth",  i, int'(depth),  vecs[i].exp_depth);
            chk("halted", i, int'(halted), int'(vecs[i].exp_halt));
            chk("fault",  i, int'(fault),  int'(vecs[i].exp_fault));
            chk("code",   i, int'(code),   vecs[i].exp_code);
        end

        // randomized run against the reference model, starting from reset
        model(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            bit       r_r, r_e, r_c;
            bit [2:0] r_o;
            int       r_t, r_f;
            r_r = ($urandom_range(0, 39) == 0);
            r_e = ($urandom_range(0, 7) != 0);
            r_o = 3'($urandom_range(0, 7));
            r_c = 1'($urandom_range(0, 1));
            r_t = int'($urandom_range(0, MASK));
            r_f = int'($urandom_range(0, MASK));
            // bias toward stack traffic so overflow/underflow occur often
            if ($urandom_range(0, 3) == 0) r_o = ($urandom_range(0, 1) == 0) ? 3'd4 : 3'd5;
            // keep HALT rare so the run spends most time in RUN
            if (r_o == 3'd6 && $urandom_range(0, 3) != 0) r_o = 3'd1;
            model(r_r, r_e, r_o, r_c, r_t, r_f);
            step(r_r, r_e, r_o, r_c, r_t, r_f);
            chk("rnd_pc",     1000 + i, int'(pc),     m_pc);
            chk("rnd_depth",  1000 + i, int'(depth),  m_stk.size());
            chk("rnd_halted", 1000 + i, int'(halted), int'(m_halt));
            chk("rnd_fault",  1000 + i, int'(fault),  int'(m_fault));
            chk("rnd_code",   1000 + i, int'(code),   m_code);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
- Parametrised program counter for the accumulator CPU datapath, generalising the plain write-enabled PC register.
- Adds:
  - an internal increment path;
  - absolute jump;
  - conditional relative branch;
  - a bounded call/return address stack;
  - a halt/fault state machine.
- Sits between the control unit (supplies op, enable, condition, target) and program memory (consumes o_pc as fetch address).

Parameters:
- N_ADDR, 11, width of PC, target, offset and stack entries.
- STACK_DEPTH, 4, number of return-address entries (>=1).
- RESET_ADDR, 0, PC value loaded on reset.

Ports:
- i_clk  input  1  clock; all state updates on falling edge.
- i_reset  input  1  reset, synchronous, active-high.
- i_en  input  1  PC write enable; low = stall, no state change.
- i_op  input  3  operation: 000 HOLD, 001 INC, 010 JUMP, 011 BRANCH, 100 CALL, 101 RET, 110 HALT, 111 reserved (treated as HOLD).
- i_cond  input  1  branch condition, used only by BRANCH.
- i_target  input  N_ADDR  absolute address for JUMP/CALL.
- i_offset  input  N_ADDR  two's-complement offset for BRANCH.
- o_pc  output  N_ADDR  current fetch address (registered).
- o_depth  output  clog2(STACK_DEPTH+1)  number of valid stack entries.
- o_halted  output  1  high in HALTED state.
- o_fault  output  1  high in FAULT state.
- o_fault_code  output  2  00 none, 01 stack overflow, 10 stack underflow.

Behaviour:
- Timing: all registers update on the falling edge of i_clk. Every output is registered and reflects the op sampled at the previous falling edge (latency 1).
- Reset (i_reset=1 at a falling edge): overrides everything, including mid-operation.
  - o_pc=RESET_ADDR, o_depth=0, o_halted=0, o_fault=0, o_fault_code=00.
  - State = RUN; stack contents don't-care.
- States: RUN, HALTED, FAULT.
  - HALTED and FAULT are sticky; the only exit is reset.
  - In HALTED/FAULT, o_pc, o_depth and the stack are frozen regardless of i_en/i_op.
- RUN with i_en=0: no change to any state (stall).
- RUN with i_en=1, per op:
  - HOLD / 111: no change.
  - INC: pc <= pc+1 (mod 2^N_ADDR; all-ones wraps to 0).
  - JUMP: pc <= i_target.
  - BRANCH:
    - i_cond=1: pc <= pc+1+i_offset.
    - i_cond=0: pc <= pc+1.
    - Arithmetic is modulo 2^N_ADDR; i_offset is sign-interpreted, with no overflow detection.
  - CALL:
    - depth<STACK_DEPTH: push pc+1 (mod 2^N) into entry [depth], depth <= depth+1, pc <= i_target.
    - depth==STACK_DEPTH: no push, pc unchanged, go to FAULT, fault_code=01.
  - RET:
    - depth>0: pc <= entry[depth-1], depth <= depth-1.
    - depth==0: pc unchanged, go to FAULT, fault_code=10.
  - HALT: pc unchanged, go to HALTED.
- Stack organisation: LIFO register array indexed by depth, not a circular buffer. Only push/pop change depth.
- Same-cycle events: a CALL at depth STACK_DEPTH-1 fills the stack without fault. A RET immediately after a CALL returns the pushed value.
- Signal validity:
  - i_cond and i_offset are ignored for all ops except BRANCH.
  - i_target is ignored except for JUMP and CALL.

Test Plan:
- Reset then INC x3 with RESET_ADDR=0 -> o_pc 0,1,2,3; o_depth=0; o_halted=0; o_fault=0.
- Wrap-around and stall:
  - pc=0x7FF, INC -> o_pc=0x000.
  - i_en=0 with op=JUMP target 0x123 -> o_pc stays 0x000.
- Branch:
  - pc=0x010, BRANCH cond=1 offset=0x7FE (-2) -> o_pc=0x00F.
  - pc=0x00F, BRANCH cond=0 -> o_pc=0x010.
- Nested calls:
  - pc=0x005, CALL 0x100 -> o_pc=0x100, depth=1.
  - CALL 0x200 -> o_pc=0x200, depth=2.
  - RET -> o_pc=0x101, depth=1.
  - RET -> o_pc=0x006, depth=0.
- Overflow/underflow:
  - STACK_DEPTH=4: five consecutive CALLs -> after the fifth, depth=4, o_pc=4th target, o_fault=1, code=01; a further INC leaves o_pc unchanged.
  - After reset, RET -> o_fault=1, code=10, o_pc=0.
- Halt and reset recovery:
  - At pc=0x042, HALT -> o_halted=1, o_pc=0x042; INC/JUMP ignored.
  - Assert i_reset for one edge -> o_pc=RESET_ADDR, o_halted=0, depth=0.
  - Reset asserted during a CALL cycle -> o_pc=RESET_ADDR, depth=0.
